// File: rtl/hc_stream_lane_adder_if.sv
// ----------------------------------------------------------------------------
// hc_stream_lane_adder_if
//   Valid/ready stream bundle carrying one cache line per transfer.
//   A transfer happens on a cycle where valid && ready.
//   valid : producer has a line on data
//   data  : DATA_WIDTH-bit line
//   ready : consumer accepts the line this cycle
//   Modports: master = producer (drives valid/data), slave = consumer
//   (drives ready).
// ----------------------------------------------------------------------------
interface hc_stream_lane_adder_if #(
  parameter int unsigned DATA_WIDTH = 512
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/hc_stream_lane_adder.sv
// ----------------------------------------------------------------------------
// hc_stream_lane_adder
//   Streaming compute core between the requestor's read-response path and
//   its write-request path. Each accepted cache line has a per-job constant
//   added to every LANE_WIDTH lane (modulo 2^LANE_WIDTH, no cross-lane
//   carry); results are queued in a show-ahead FIFO and handed back for
//   write-out. One job runs per start pulse; finish goes high once
//   total_lines lines have left the FIFO.
//
//   clk, reset   : core clock, synchronous active-high reset
//   start        : one-cycle pulse, begins a job (ignored while running)
//   total_lines  : lines in the job, sampled on start
//   addend       : constant added to each lane, sampled on start
//   finish       : high while the job is complete
//   rd           : input line stream (slave)  - rd.valid/rd.data/rd.ready
//   wr           : output line stream (master) - wr.valid/wr.data/wr.ready
//   occupancy    : FIFO fill level, 0..FIFO_DEPTH
// ----------------------------------------------------------------------------
module hc_stream_lane_adder #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned LANE_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [COUNT_WIDTH-1:0]        total_lines,
  input  logic [LANE_WIDTH-1:0]         addend,
  output logic                          finish,
  hc_stream_lane_adder_if.slave         rd,
  hc_stream_lane_adder_if.master        wr,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_WIDTH = PTR_WIDTH + 1;
  localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic [COUNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [COUNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [LANE_WIDTH-1:0]  addend_q, addend_d;
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_WIDTH-1:0]   occ_q, occ_d;
  logic                   rd_ready_q, rd_ready_d;
  logic                   wr_valid_q, wr_valid_d;
  logic                   finish_q, finish_d;

  logic                   push;
  logic                   pop;
  logic [DATA_WIDTH-1:0]  sum_line;
  logic [DATA_WIDTH-1:0]  fifo_mem_q [FIFO_DEPTH];

  // rd_ready_q is only ever high in RUN, so a push needs no state qualifier.
  assign push = rd.valid && rd_ready_q;
  assign pop  = wr_valid_q && wr.ready;

  // Independent per-lane adders; each sum truncates to its own lane.
  always_comb begin
    sum_line = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      sum_line[i*LANE_WIDTH +: LANE_WIDTH] =
        rd.data[i*LANE_WIDTH +: LANE_WIDTH] + addend_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    addend_d  = addend_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      in_cnt_d = in_cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      out_cnt_d = out_cnt_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          total_d   = total_lines;
          addend_d  = addend;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (total_lines == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Looking at the post-pop count lets finish rise in the cycle right
        // after the final output transfer.
        if (out_cnt_d == total_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they always describe
    // the cycle they are presented in.
    rd_ready_d = (state_d == RUN) && (in_cnt_d < total_d) && (occ_d < OCC_FULL);
    wr_valid_d = (occ_d != '0);
    finish_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      total_q    <= '0;
      addend_q   <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rd_ready_q <= 1'b0;
      wr_valid_q <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      addend_q   <= addend_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rd_ready_q <= rd_ready_d;
      wr_valid_q <= wr_valid_d;
      finish_q   <= finish_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= sum_line;
    end
  end

  assign rd.ready  = rd_ready_q;
  assign wr.valid  = wr_valid_q;
  assign wr.data   = fifo_mem_q[rd_ptr_q];
  assign finish    = finish_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_hc_stream_lane_adder.sv
// ----------------------------------------------------------------------------
// tb_hc_stream_lane_adder
//   Directed bench for hc_stream_lane_adder: basic job, lane wrap, full FIFO
//   back-pressure, zero-length job, randomised handshakes, reset mid-job.
// ----------------------------------------------------------------------------
module tb_hc_stream_lane_adder;

  localparam int unsigned DW    = 512;
  localparam int unsigned LW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 32;
  localparam int unsigned NL    = DW / LW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] total_lines;
  logic [LW-1:0] addend;
  logic          finish;
  logic [4:0]    occupancy;

  hc_stream_lane_adder_if #(.DATA_WIDTH(DW)) rd_if ();
  hc_stream_lane_adder_if #(.DATA_WIDTH(DW)) wr_if ();

  always #5 clk = ~clk;

  hc_stream_lane_adder #(
    .DATA_WIDTH (DW),
    .LANE_WIDTH (LW),
    .FIFO_DEPTH (DEPTH),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .total_lines(total_lines),
    .addend     (addend),
    .finish     (finish),
    .rd         (rd_if),
    .wr         (wr_if),
    .occupancy  (occupancy)
  );

  int            errors = 0;
  int            checks = 0;
  int            n_in;
  int            n_out;
  bit            rand_mode = 1'b0;
  bit            last_pop_fin;
  logic [LW-1:0] cur_add;
  logic [DW-1:0] src_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] tmp;

  function automatic logic [DW-1:0] mk_line(input logic [LW-1:0] base);
    logic [DW-1:0] r;
    for (int j = 0; j < NL; j++) r[j*LW +: LW] = base + LW'(j);
    return r;
  endfunction

  function automatic logic [DW-1:0] add_lanes(input logic [DW-1:0] l, input logic [LW-1:0] a);
    logic [DW-1:0] r;
    for (int j = 0; j < NL; j++) r[j*LW +: LW] = l[j*LW +: LW] + a;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: account for transfers at the upcoming edge, then update drive.
  task automatic tick();
    logic          pushed;
    logic          popped;
    logic [DW-1:0] d;
    @(negedge clk);
    pushed = rd_if.valid && rd_if.ready;
    popped = wr_if.valid && wr_if.ready;
    if (rand_mode) chk("occ_range", DW'(occupancy <= 5'd16), DW'(1));
    if (popped) begin
      got_q.push_back(wr_if.data);
      last_pop_fin = finish;
      chk("out_avail", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) begin
        d = exp_q.pop_front();
        chk("out_data", wr_if.data, d);
      end
      n_out++;
    end
    if (pushed) begin
      exp_q.push_back(add_lanes(rd_if.data, cur_add));
      n_in++;
    end
    @(posedge clk);
    #1;
    if (n_in < src_q.size()) rd_if.data = src_q[n_in];
    if (rand_mode) begin
      if (!rd_if.valid || pushed) rd_if.valid = ($urandom_range(0, 1) == 1);
      wr_if.ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic start_job(input logic [CW-1:0] t, input logic [LW-1:0] a);
    total_lines = t;
    addend      = a;
    cur_add     = a;
    n_in        = 0;
    n_out       = 0;
    exp_q.delete();
    got_q.delete();
    if (src_q.size() > 0) rd_if.data = src_q[0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_until(input int total, input int budget);
    int c = 0;
    while (n_out < total && c < budget) begin
      tick();
      c++;
    end
    chk("out_count", DW'(n_out), DW'(total));
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    total_lines = '0;
    addend      = '0;
    rd_if.valid = 1'b0;
    rd_if.data  = '0;
    wr_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_finish", DW'(finish), DW'(0));
    chk("rst_rd_ready", DW'(rd_if.ready), DW'(0));
    chk("rst_wr_valid", DW'(wr_if.valid), DW'(0));
    chk("rst_occupancy", DW'(occupancy), DW'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: four lines, addend 1, lanes 0..63 -> 1..64
    src_q.delete();
    for (int k = 0; k < 4; k++) src_q.push_back(mk_line(LW'(k * 16)));
    rd_if.valid = 1'b1;
    wr_if.ready = 1'b1;
    start_job(32'd4, 32'd1);
    run_until(4, 60);
    chk("t1_finish_at_last_pop", DW'(last_pop_fin), DW'(0));
    chk("t1_finish_after", DW'(finish), DW'(1));
    chk("t1_n_in", DW'(n_in), DW'(4));
    tmp = got_q[0];
    chk("t1_l0_lane0", DW'(tmp[31:0]), DW'(32'd1));
    tmp = got_q[1];
    chk("t1_l1_lane7", DW'(tmp[7*LW +: LW]), DW'(32'd24));
    tmp = got_q[3];
    chk("t1_l3_lane15", DW'(tmp[511:480]), DW'(32'd64));
    chk("t1_rd_ready_done", DW'(rd_if.ready), DW'(0));

    // 2: lane wrap with addend all-ones, no cross-lane carry
    src_q.delete();
    tmp = '0;
    for (int j = 0; j < NL; j += 2) tmp[j*LW +: LW] = 32'd1;
    src_q.push_back(tmp);
    tmp = '0;
    tmp[3*LW +: LW] = 32'd1;
    src_q.push_back(tmp);
    start_job(32'd2, 32'hFFFF_FFFF);
    run_until(2, 40);
    tmp = got_q[0];
    chk("t2_l0_lane0", DW'(tmp[0 +: LW]), DW'(32'h0000_0000));
    chk("t2_l0_lane1", DW'(tmp[LW +: LW]), DW'(32'hFFFF_FFFF));
    tmp = got_q[1];
    chk("t2_l1_lane2", DW'(tmp[2*LW +: LW]), DW'(32'hFFFF_FFFF));
    chk("t2_l1_lane3", DW'(tmp[3*LW +: LW]), DW'(32'h0000_0000));
    chk("t2_l1_lane4", DW'(tmp[4*LW +: LW]), DW'(32'hFFFF_FFFF));

    // 3: back-pressure fills the FIFO, start in RUN ignored, then drain
    src_q.delete();
    for (int k = 0; k < 40; k++) src_q.push_back(mk_line(LW'(1000 + k * 16)));
    wr_if.ready = 1'b0;
    start_job(32'd40, 32'h10);
    repeat (30) tick();
    chk("t3_n_in_full", DW'(n_in), DW'(16));
    chk("t3_rd_ready_full", DW'(rd_if.ready), DW'(0));
    chk("t3_occ_full", DW'(occupancy), DW'(16));
    chk("t3_wr_valid_full", DW'(wr_if.valid), DW'(1));
    total_lines = 32'd3;
    addend      = 32'd5;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    chk("t3_start_ignored_occ", DW'(occupancy), DW'(16));
    chk("t3_start_ignored_fin", DW'(finish), DW'(0));
    wr_if.ready = 1'b1;
    #1;
    chk("t3_no_bypass", DW'(rd_if.ready), DW'(0));
    run_until(40, 200);
    chk("t3_n_in_total", DW'(n_in), DW'(40));

    // 4: zero-length job from IDLE
    rd_if.valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t4_finish_idle", DW'(finish), DW'(0));
    src_q.delete();
    rd_if.valid = 1'b1;
    start_job(32'd0, 32'd0);
    chk("t4_finish", DW'(finish), DW'(1));
    repeat (4) begin
      tick();
      chk("t4_rd_ready", DW'(rd_if.ready), DW'(0));
    end
    chk("t4_n_in", DW'(n_in), DW'(0));

    // 5: randomised handshakes over a long job
    src_q.delete();
    for (int k = 0; k < 1000; k++) src_q.push_back(mk_line($urandom));
    rand_mode = 1'b1;
    start_job(32'd1000, 32'h1234_5678);
    chk("t5_finish_drops", DW'(finish), DW'(0));
    run_until(1000, 20000);
    rand_mode = 1'b0;
    chk("t5_n_in", DW'(n_in), DW'(1000));
    chk("t5_finish", DW'(finish), DW'(1));

    // 6: reset mid-job discards FIFO contents; a fresh job follows
    src_q.delete();
    for (int k = 0; k < 20; k++) src_q.push_back(mk_line(LW'(3000 + k * 16)));
    rd_if.valid = 1'b1;
    wr_if.ready = 1'b0;
    start_job(32'd20, 32'd3);
    begin
      int c = 0;
      while (n_in < 5 && c < 50) begin
        tick();
        c++;
      end
    end
    chk("t6_n_in", DW'(n_in), DW'(5));
    chk("t6_occ_before", DW'(occupancy), DW'(5));
    rd_if.valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_occ", DW'(occupancy), DW'(0));
    chk("t6_rst_wr_valid", DW'(wr_if.valid), DW'(0));
    chk("t6_rst_finish", DW'(finish), DW'(0));
    chk("t6_rst_rd_ready", DW'(rd_if.ready), DW'(0));
    reset = 1'b0;
    src_q.delete();
    src_q.push_back(mk_line(32'd5000));
    src_q.push_back(mk_line(32'd6000));
    wr_if.ready = 1'b1;
    rd_if.valid = 1'b1;
    start_job(32'd2, 32'd7);
    run_until(2, 40);
    chk("t6_finish", DW'(finish), DW'(1));
    tmp = got_q[0];
    chk("t6_l0_lane0", DW'(tmp[0 +: LW]), DW'(32'd5007));
    repeat (5) begin
      tick();
      chk("t6_no_extra", DW'(wr_if.valid), DW'(0));
    end
    chk("t6_n_out", DW'(n_out), DW'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
